// File: rtl/tlast_packet_sequencer.sv
// Frames a free-running AXI4-Stream source into fixed-length packets with tlast,
// counting packets and ending a run after a programmed count or on a stop request.
module tlast_packet_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] packet_len,
  input  logic [COUNT_WIDTH-1:0] num_packets,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] packets_sent
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] len_reg;
  logic [COUNT_WIDTH-1:0] num_reg;
  logic [COUNT_WIDTH-1:0] beat_cnt_reg;
  logic [COUNT_WIDTH-1:0] pkt_cnt_reg;
  logic [COUNT_WIDTH-1:0] packets_sent_reg;
  logic                   stop_pending_reg;
  logic                   out_valid_reg;
  logic                   out_last_reg;
  logic [DATA_WIDTH-1:0]  out_data_reg;
  logic                   done_reg;

  logic s_ready_next;
  logic accept;
  logic m_hs;
  logic last_beat;
  logic done_next;
  logic start_run;

  assign m_hs      = out_valid_reg && m_axis_tready;
  assign last_beat = (beat_cnt_reg == len_reg - CNT_ONE);
  assign start_run = (state_reg == IDLE) && start;

  always_comb begin
    state_next   = state_reg;
    s_ready_next = 1'b0;
    accept       = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Always ready so the free-running source never backs up while idle.
        s_ready_next = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        s_ready_next = !out_valid_reg || m_axis_tready;
        accept       = s_axis_tvalid && s_ready_next;
        if (accept && last_beat) begin
          if ((num_reg != '0 && pkt_cnt_reg + CNT_ONE == num_reg) || stop_pending_reg || stop)
            state_next = DRAIN;
        end else if (!accept && beat_cnt_reg == '0 && (stop || stop_pending_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_reg || m_hs) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Run configuration and counters; a zero packet length is promoted to one beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_reg          <= '0;
      num_reg          <= '0;
      beat_cnt_reg     <= '0;
      pkt_cnt_reg      <= '0;
      packets_sent_reg <= '0;
      stop_pending_reg <= 1'b0;
    end else if (start_run) begin
      len_reg          <= (packet_len == '0) ? CNT_ONE : packet_len;
      num_reg          <= num_packets;
      beat_cnt_reg     <= '0;
      pkt_cnt_reg      <= '0;
      packets_sent_reg <= '0;
      stop_pending_reg <= 1'b0;
    end else begin
      if (state_reg == RUN && stop) stop_pending_reg <= 1'b1;
      if (accept) begin
        beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + CNT_ONE;
        if (last_beat) pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
      end
      if (m_hs && out_last_reg) packets_sent_reg <= packets_sent_reg + CNT_ONE;
    end
  end

  // Single register slice toward the DMA; contents hold while the sink stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= last_beat;
      out_data_reg  <= s_axis_tdata;
    end else if (m_hs) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  assign s_axis_tready = s_ready_next;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tlast  = out_last_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign packets_sent  = packets_sent_reg;

endmodule

// File: tb/tb_tlast_packet_sequencer.sv
// Bench for tlast_packet_sequencer: directed scenarios plus randomized runs checked
// against a beat-count model of how many beats each run must emit.
module tb_tlast_packet_sequencer;

  localparam int DW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] packet_len = '0;
  logic [CW-1:0] num_packets = '0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic [CW-1:0] packets_sent;

  tlast_packet_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .packet_len(packet_len), .num_packets(num_packets),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .busy(busy), .done(done), .packets_sent(packets_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] src;
  logic [DW-1:0] out_data_q[$];
  bit            out_last_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_total;
  int            leff;
  int            done_cnt;
  int            stable_err;
  int            ready_err;
  bit            timed_out;
  int            last_hs_cyc;
  int            done_cyc;
  logic [CW-1:0] ps_final;
  logic          busy_final;

  // Drives one run; the model only counts beats: the run emits the first T source beats
  // accepted after start, T = N*L, or on stop the accepted beats rounded up to a packet.
  task automatic run_stream(input int l_cfg, input int n_cfg, input int valid_pct,
                            input int ready_mode, input int stop_at, input bit noise);
    int k, cyc;
    longint tgt, t;
    bit tgt_inf, active, stop_now, stop_sent, s_hs, m_hs, pv, pr, pl;
    logic [DW-1:0] pd;
    out_data_q.delete(); out_last_q.delete(); exp_q.delete();
    done_cnt = 0; stable_err = 0; ready_err = 0; last_hs_cyc = -1; done_cyc = -1;
    leff = (l_cfg == 0) ? 1 : l_cfg;
    tgt_inf = (n_cfg == 0);
    tgt = longint'(n_cfg) * leff;
    k = 0; cyc = 0; stop_sent = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    @(negedge clk);
    packet_len = CW'(l_cfg); num_packets = CW'(n_cfg);
    start = 1'b1; stop = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; stop = 1'b0; stop_now = 0;
      packet_len = $urandom; num_packets = CW'($urandom_range(0, 3));
      active = tgt_inf || (k < tgt);
      if (active && !stop_sent && stop_at >= 0 && k == stop_at) begin
        stop = 1'b1; stop_now = 1; stop_sent = 1;
      end else if (noise && active && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
      s_tvalid = ($urandom_range(1, 100) <= valid_pct);
      s_tdata  = src;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2) == 1;
        default: m_tready = $urandom_range(0, 1) == 1;
      endcase
      #1;
      if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stable_err++;
      if (m_tvalid && !m_tready && s_tready) ready_err++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      s_hs = s_tvalid && s_tready;
      m_hs = m_tvalid && m_tready;
      if (m_hs) begin
        out_data_q.push_back(m_tdata); out_last_q.push_back(m_tlast); last_hs_cyc = cyc;
      end
      if (stop_now) begin
        t = ((longint'(k) + longint'(s_hs) + leff - 1) / leff) * leff;
        if (!tgt_inf && t > tgt) t = tgt;
        tgt = t; tgt_inf = 0;
      end
      if (s_hs) begin
        if (tgt_inf || k < tgt) begin exp_q.push_back(src); k++; end
        src++;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
      if (done_cnt > 0 && cyc - done_cyc >= 3) break;
    end
    timed_out = (done_cnt == 0);
    exp_total = tgt_inf ? -1 : int'(tgt);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; s_tvalid = 1'b0;
    #1;
    ps_final = packets_sent; busy_final = busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin
      n_bad++; $display("FAIL reset_out: valid=%b last=%b data=%h required 0/0/0", m_tvalid, m_tlast, m_tdata); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || packets_sent !== '0) begin
      n_bad++; $display("FAIL reset_status: busy=%b done=%b sent=%0d required 0/0/0", busy, done, packets_sent); end
    resetn = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (s_tready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: tready=%b busy=%b required 1/0", s_tready, busy); end
    $display("reset: released, idle checked");
  endtask

  task automatic test_idle();
    int errs;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = $urandom; m_tready = $urandom_range(0, 1) == 1;
      stop = (i == 5);
      #1;
      n_cmp++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++; errs++;
        $display("FAIL idle_cycle%0d: tready=%b mvalid=%b busy=%b done=%b required 1/0/0/0", i, s_tready, m_tvalid, busy, done);
      end
    end
    @(negedge clk); stop = 1'b0; s_tvalid = 1'b0;
    $display("idle: 10 source beats discarded, stop ignored, errors=%0d", errs);
  endtask

  task automatic test_basic();
    src = '0;
    run_stream(4, 2, 100, 0, -1, 1);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL basic_timeout: done_cnt=%0d required 1", done_cnt); end
    n_cmp++; if (out_data_q.size() !== 8) begin
      n_bad++; $display("FAIL basic_count: beats=%0d required 8", out_data_q.size()); end
    for (int i = 0; i < out_data_q.size() && i < 8; i++) begin
      n_cmp++; if (out_data_q[i] !== DW'(i) || out_last_q[i] !== (i == 3 || i == 7)) begin
        n_bad++; $display("FAIL basic_beat%0d: data=%0d last=%b required %0d/%b", i, out_data_q[i], out_last_q[i], i, (i == 3 || i == 7)); end
    end
    n_cmp++; if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
      n_bad++; $display("FAIL basic_done: pulses=%0d at cyc %0d required 1 at cyc %0d", done_cnt, done_cyc, last_hs_cyc + 1); end
    n_cmp++; if (ps_final !== CW'(2) || busy_final !== 1'b0) begin
      n_bad++; $display("FAIL basic_status: sent=%0d busy=%b required 2/0", ps_final, busy_final); end
    $display("basic: len=4 num=2 beats=%0d sent=%0d", out_data_q.size(), ps_final);
  endtask

  task automatic test_backpressure();
    src = '0;
    run_stream(4, 2, 100, 1, -1, 1);
    n_cmp++; if (timed_out || out_data_q.size() !== 8) begin
      n_bad++; $display("FAIL bp_count: beats=%0d timeout=%b required 8/0", out_data_q.size(), timed_out); end
    for (int i = 0; i < out_data_q.size() && i < 8; i++) begin
      n_cmp++; if (out_data_q[i] !== DW'(i) || out_last_q[i] !== (i == 3 || i == 7)) begin
        n_bad++; $display("FAIL bp_beat%0d: data=%0d last=%b required %0d/%b", i, out_data_q[i], out_last_q[i], i, (i == 3 || i == 7)); end
    end
    n_cmp++; if (stable_err !== 0 || ready_err !== 0) begin
      n_bad++; $display("FAIL bp_stall: unstable=%0d ready_violations=%0d required 0/0", stable_err, ready_err); end
    n_cmp++; if (ps_final !== CW'(2) || done_cnt !== 1) begin
      n_bad++; $display("FAIL bp_status: sent=%0d done=%0d required 2/1", ps_final, done_cnt); end
    $display("backpressure: tready 1010.. beats=%0d sent=%0d", out_data_q.size(), ps_final);
  endtask

  task automatic test_stop();
    src = '0;
    run_stream(5, 0, 100, 0, 7, 0);
    n_cmp++; if (timed_out || out_data_q.size() !== 10) begin
      n_bad++; $display("FAIL stop_count: beats=%0d timeout=%b required 10/0", out_data_q.size(), timed_out); end
    for (int i = 0; i < out_data_q.size() && i < 10; i++) begin
      n_cmp++; if (out_data_q[i] !== DW'(i) || out_last_q[i] !== (i == 4 || i == 9)) begin
        n_bad++; $display("FAIL stop_beat%0d: data=%0d last=%b required %0d/%b", i, out_data_q[i], out_last_q[i], i, (i == 4 || i == 9)); end
    end
    n_cmp++; if (ps_final !== CW'(2) || done_cnt !== 1 || busy_final !== 1'b0) begin
      n_bad++; $display("FAIL stop_status: sent=%0d done=%0d busy=%b required 2/1/0", ps_final, done_cnt, busy_final); end
    $display("stop: len=5 stop after 7 beats, beats=%0d sent=%0d", out_data_q.size(), ps_final);
  endtask

  task automatic test_len_zero();
    src = '0;
    run_stream(0, 3, 70, 2, -1, 0);
    n_cmp++; if (timed_out || out_data_q.size() !== 3) begin
      n_bad++; $display("FAIL len0_count: beats=%0d timeout=%b required 3/0", out_data_q.size(), timed_out); end
    for (int i = 0; i < out_data_q.size() && i < 3; i++) begin
      n_cmp++; if (out_data_q[i] !== DW'(i) || out_last_q[i] !== 1'b1) begin
        n_bad++; $display("FAIL len0_beat%0d: data=%0d last=%b required %0d/1", i, out_data_q[i], out_last_q[i], i); end
    end
    n_cmp++; if (ps_final !== CW'(3) || busy_final !== 1'b0 || done_cnt !== 1) begin
      n_bad++; $display("FAIL len0_status: sent=%0d busy=%b done=%0d required 3/0/1", ps_final, busy_final, done_cnt); end
    $display("len_zero: num=3 beats=%0d sent=%0d", out_data_q.size(), ps_final);
  endtask

  task automatic test_random();
    int l, n, sa, vp;
    for (int r = 0; r < 10; r++) begin
      l  = $urandom_range(0, 6);
      n  = $urandom_range(0, 4);
      vp = $urandom_range(40, 100);
      if (n == 0) sa = $urandom_range(0, 15);
      else        sa = ($urandom_range(0, 1) == 1) ? -1 : $urandom_range(0, n * ((l == 0) ? 1 : l));
      run_stream(l, n, vp, 2, sa, 1);
      n_cmp++; if (timed_out || out_data_q.size() !== exp_total) begin
        n_bad++; $display("FAIL rand%0d_count: beats=%0d timeout=%b required %0d/0", r, out_data_q.size(), timed_out, exp_total); end
      for (int i = 0; i < out_data_q.size() && i < exp_q.size(); i++) begin
        n_cmp++; if (out_data_q[i] !== exp_q[i] || out_last_q[i] !== ((i + 1) % leff == 0)) begin
          n_bad++; $display("FAIL rand%0d_beat%0d: data=%h last=%b required %h/%b", r, i, out_data_q[i], out_last_q[i], exp_q[i], ((i + 1) % leff == 0)); end
      end
      n_cmp++; if (stable_err !== 0 || ready_err !== 0 || done_cnt !== 1) begin
        n_bad++; $display("FAIL rand%0d_proto: unstable=%0d ready_violations=%0d done=%0d required 0/0/1", r, stable_err, ready_err, done_cnt); end
      n_cmp++; if (exp_total >= 0 && (ps_final !== CW'(exp_total / leff) || busy_final !== 1'b0)) begin
        n_bad++; $display("FAIL rand%0d_status: sent=%0d busy=%b required %0d/0", r, ps_final, busy_final, exp_total / leff); end
      $display("random%0d: len=%0d num=%0d stop_at=%0d beats=%0d required=%0d sent=%0d", r, l, n, sa, out_data_q.size(), exp_total, ps_final);
    end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    packet_len = CW'(2); num_packets = '0; start = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
    src = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; s_tvalid = 1'b1; s_tdata = src; m_tready = 1'b1;
      #1; if (s_tready) src++;
    end
    @(negedge clk);
    s_tdata = src; m_tready = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== DW'(3) || packets_sent !== CW'(1)) begin
      n_bad++; $display("FAIL rmp_before: valid=%b last=%b data=%0d sent=%0d required 1/1/3/1", m_tvalid, m_tlast, m_tdata, packets_sent); end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || busy !== 1'b0 || packets_sent !== '0) begin
      n_bad++; $display("FAIL rmp_async: valid=%b last=%b busy=%b sent=%0d required 0/0/0/0", m_tvalid, m_tlast, busy, packets_sent); end
    @(negedge clk);
    resetn = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (m_tvalid !== 1'b0 || busy !== 1'b0 || packets_sent !== '0 || s_tready !== 1'b1) begin
      n_bad++; $display("FAIL rmp_after: valid=%b busy=%b sent=%0d tready=%b required 0/0/0/1", m_tvalid, busy, packets_sent, s_tready); end
    s_tvalid = 1'b0;
    $display("reset_mid_packet: output cleared, idle after release");
  endtask

  initial begin
    src = '0;
    test_reset();
    test_idle();
    test_basic();
    test_backpressure();
    test_stop();
    test_len_zero();
    test_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
